rmw_sequencer: RTL

RMW_SEQUENCER -- requirements
Module: rmw_sequencer

---
 rtl/rmw_sequencer_pkg.sv | 30 +++
 rtl/rmw_sequencer_if.sv | 35 +++
 rtl/rmw_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rmw_sequencer_pkg.sv
// Shared ALU op-code and status-register definitions used by the RMW sequencer.
// Status bit layout follows the 6502 P register with the unused bit 5 removed.
package rmw_sequencer_pkg;

    localparam logic [4:0] ALU_ADC = 5'd0;
    localparam logic [4:0] ALU_SBC = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_ORA = 5'd3;
    localparam logic [4:0] ALU_EOR = 5'd4;
    localparam logic [4:0] ALU_ASL = 5'd5;
    localparam logic [4:0] ALU_LSR = 5'd6;
    localparam logic [4:0] ALU_ROL = 5'd7;
    localparam logic [4:0] ALU_ROR = 5'd8;
    localparam logic [4:0] ALU_INC = 5'd9;
    localparam logic [4:0] ALU_DEC = 5'd10;
    localparam logic [4:0] ALU_NOP = 5'h1F;

    localparam int unsigned STATUS_C = 0;
    localparam int unsigned STATUS_Z = 1;
    localparam int unsigned STATUS_N = 6;

    function automatic logic is_shift_op(logic [4:0] op);
        return (op == ALU_ASL) || (op == ALU_LSR) || (op == ALU_ROL) || (op == ALU_ROR);
    endfunction

    function automatic logic is_rmw_op(logic [4:0] op);
        return is_shift_op(op) || (op == ALU_INC) || (op == ALU_DEC);
    endfunction

endpackage

// File: rtl/rmw_sequencer_if.sv
// Request, memory-bus, ALU and status-register signals of the RMW sequencer.
interface rmw_sequencer_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              start;
    logic [4:0]        op_in;
    logic [ADDR_W-1:0] addr_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rw;
    logic [7:0]        bus_data_in;
    logic [7:0]        bus_data_out;
    logic [4:0]        alu_op;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [7:0]        alu_result;
    logic [6:0]        alu_flags;
    logic [6:0]        status_in;
    logic [6:0]        status_out;
    logic              status_we;

    modport master (
        output start, op_in, addr_in, bus_data_in, alu_result, alu_flags, status_in,
        input  busy, done, err, bus_addr, bus_rw, bus_data_out, alu_op, alu_a, alu_b,
        input  status_out, status_we
    );

    modport slave (
        input  start, op_in, addr_in, bus_data_in, alu_result, alu_flags, status_in,
        output busy, done, err, bus_addr, bus_rw, bus_data_out, alu_op, alu_a, alu_b,
        output status_out, status_we
    );
endinterface

// File: rtl/rmw_sequencer.sv
// Read-modify-write sequencer for 6502 shift/rotate/inc/dec on memory operands:
// READ, MODIFY (dummy write, ALU runs), WRITE (result and status update).
module rmw_sequencer
    import rmw_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input logic           clk,
    input logic           rst,
    rmw_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_MODIFY = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StRead   = ST_READ,
        StModify = ST_MODIFY,
        StWrite  = ST_WRITE
    } state_e;

    state_e            state_q;
    logic [4:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        operand_q;
    logic              flag_c_q, flag_z_q, flag_n_q;
    logic              busy_q, done_q, err_q, rw_q, we_q;
    logic [4:0]        alu_op_q;
    logic [7:0]        alu_a_q;
    logic              unused_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rw_q      <= 1'b1;
            we_q      <= 1'b0;
            alu_op_q  <= ALU_NOP;
            alu_a_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (is_rmw_op(bus.op_in)) begin
                            state_q <= StRead;
                            op_q    <= bus.op_in;
                            addr_q  <= bus.addr_in;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    state_q   <= StModify;
                    operand_q <= bus.bus_data_in;
                    rw_q      <= 1'b0;
                    alu_op_q  <= op_q;
                    alu_a_q   <= bus.bus_data_in;
                end
                StModify: begin
                    // ALU flags settle on the falling edge inside MODIFY
                    state_q  <= StWrite;
                    flag_c_q <= bus.alu_flags[STATUS_C];
                    flag_z_q <= bus.alu_flags[STATUS_Z];
                    flag_n_q <= bus.alu_flags[STATUS_N];
                    we_q     <= 1'b1;
                    alu_op_q <= ALU_NOP;
                    alu_a_q  <= '0;
                end
                StWrite: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    we_q    <= 1'b0;
                    rw_q    <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Data outputs follow the state directly: alu_result is already registered by the ALU
    always_comb begin
        bus.bus_data_out = 8'h00;
        bus.status_out   = bus.status_in;
        if (state_q == StModify) begin
            bus.bus_data_out = operand_q;
        end else if (state_q == StWrite) begin
            bus.bus_data_out         = bus.alu_result;
            bus.status_out[STATUS_Z] = flag_z_q;
            bus.status_out[STATUS_N] = flag_n_q;
            if (is_shift_op(op_q)) begin
                bus.status_out[STATUS_C] = flag_c_q;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_rw    = rw_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = 8'h00;
    assign bus.status_we = we_q;
    assign unused_flags  = ^bus.alu_flags;

endmodule
